dispatch_ctrl: RTL

DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

---
 rtl/dispatch_ctrl_pkg.sv | 37 +++
 rtl/rs_credit_ctr.sv | 46 ++++
 rtl/dispatch_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/dispatch_ctrl_pkg.sv
// Shared reservation-station encodings and sizing helpers for the dispatch stage.
`ifndef DISPATCH_CONSTANTS_VH
`define DISPATCH_CONSTANTS_VH
`define RS_SEL  2
`define RS_ALU  2'd0
`define RS_MUL  2'd1
`define RS_LDST 2'd2
`define RS_BR   2'd3
`define RS_NUM  4
`endif

package dispatch_ctrl_pkg;
  localparam int RS_SEL_W = `RS_SEL;
  localparam int RS_NUM   = `RS_NUM;

  typedef logic [RS_SEL_W-1:0] rs_sel_t;

  localparam rs_sel_t RS_ALU  = `RS_ALU;
  localparam rs_sel_t RS_MUL  = `RS_MUL;
  localparam rs_sel_t RS_LDST = `RS_LDST;
  localparam rs_sel_t RS_BR   = `RS_BR;

  // Two-entry dispatch stage; v is always packed toward slot0.
  typedef struct packed {
    logic [1:0] v;
    rs_sel_t    sel0;
    rs_sel_t    sel1;
  } stage_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/rs_credit_ctr.sv
// Free-entry credit counter for one reservation station: up to two dispatches
// and two releases per cycle, flush restores the full depth.
module rs_credit_ctr
  import dispatch_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int W = cnt_w(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [1:0]   disp_cnt,
  input  logic [1:0]   rel_cnt,
  output logic [W-1:0] count
);
  localparam logic [W+1:0] DEPTH_X = (W+2)'(DEPTH);

  logic [W-1:0] count_reg, count_next;
  logic [W+1:0] sum_up, disp_ext;

  // Sum is formed two bits wider so an illegal over/underflow stays visible.
  always_comb begin
    disp_ext   = {{W{1'b0}}, disp_cnt};
    sum_up     = {2'b00, count_reg} + {{W{1'b0}}, rel_cnt};
    count_next = flush ? W'(DEPTH) : W'(sum_up - disp_ext);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= W'(DEPTH);
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    flush || (sum_up >= disp_ext));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    flush || ((sum_up - disp_ext) <= DEPTH_X));
  a_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    {2'b00, count_reg} <= DEPTH_X);
`endif
endmodule

// File: rtl/dispatch_ctrl.sv
// Two-wide in-order dispatch stage with per-RS credit tracking; a decoded pair
// is captured one cycle and dispatched as soon as its target stations have room.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ALU_DEPTH  = 8,
  parameter int MUL_DEPTH  = 4,
  parameter int LDST_DEPTH = 8,
  parameter int BR_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic [1:0]            i_dec_valid,
  input  logic [RS_SEL_W-1:0]   i_dec_rs_sel0,
  input  logic [RS_SEL_W-1:0]   i_dec_rs_sel1,
  output logic                  o_dec_ready,
  input  logic [2*RS_NUM-1:0]   i_rel_cnt,
  output logic [1:0]            o_dis_valid,
  output logic [RS_SEL_W-1:0]   o_dis_rs_sel0,
  output logic [RS_SEL_W-1:0]   o_dis_rs_sel1,
  output logic                  o_shift,
  output logic                  o_stage_en
);
  localparam int CW = cnt_w(max2(max2(ALU_DEPTH, MUL_DEPTH), max2(LDST_DEPTH, BR_DEPTH)));

  stage_t        stage_reg, stage_next;
  logic [CW-1:0] credit [RS_NUM];
  logic          disp0, disp1, all_go;

  // Slot1 may only go behind slot0; a shared target needs two free entries.
  always_comb begin
    disp0 = 1'b0;
    disp1 = 1'b0;
    if (!i_flush && stage_reg.v[0] && (credit[stage_reg.sel0] != '0)) begin
      disp0 = 1'b1;
      if (stage_reg.v[1]) begin
        disp1 = (stage_reg.sel1 == stage_reg.sel0) ? (credit[stage_reg.sel1] > CW'(1))
                                                   : (credit[stage_reg.sel1] != '0);
      end
    end
  end

  assign all_go        = !stage_reg.v[0] || (disp0 && (!stage_reg.v[1] || disp1));
  assign o_dec_ready   = i_rst_n && !i_flush && all_go;
  assign o_stage_en    = o_dec_ready && (i_dec_valid != 2'b00);
  assign o_shift       = disp0 && stage_reg.v[1] && !disp1;
  assign o_dis_valid   = {disp1, disp0};
  assign o_dis_rs_sel0 = stage_reg.sel0;
  assign o_dis_rs_sel1 = stage_reg.sel1;

  always_comb begin
    stage_next = stage_reg;
    if (i_flush) begin
      stage_next = '0;
    end else if (o_stage_en) begin
      stage_next.v    = i_dec_valid[0] ? i_dec_valid : 2'b01;
      stage_next.sel0 = i_dec_valid[0] ? i_dec_rs_sel0 : i_dec_rs_sel1;
      stage_next.sel1 = i_dec_rs_sel1;
    end else if (o_dec_ready) begin
      stage_next.v = 2'b00;
    end else if (o_shift) begin
      stage_next.v    = 2'b01;
      stage_next.sel0 = stage_reg.sel1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  generate
    for (genvar gi = 0; gi < RS_NUM; gi++) begin : g_rs
      localparam int D = (gi == int'(RS_ALU))  ? ALU_DEPTH  :
                         (gi == int'(RS_MUL))  ? MUL_DEPTH  :
                         (gi == int'(RS_LDST)) ? LDST_DEPTH : BR_DEPTH;
      localparam int W = cnt_w(D);

      logic [1:0]   disp_cnt;
      logic [W-1:0] cnt;

      assign disp_cnt = {1'b0, disp0 && (stage_reg.sel0 == RS_SEL_W'(gi))}
                      + {1'b0, disp1 && (stage_reg.sel1 == RS_SEL_W'(gi))};

      rs_credit_ctr #(.DEPTH(D)) u_ctr (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .flush    (i_flush),
        .disp_cnt (disp_cnt),
        .rel_cnt  (i_rel_cnt[2*gi +: 2]),
        .count    (cnt)
      );

      assign credit[gi] = CW'(cnt);
    end
  endgenerate
endmodule
